// File: rtl/shake_squeeze_dump.sv
// SHAKE output dump stage: captures one squeezed rate block, then streams it
// out as W-bit AXI-stream style beats with byte keep, last marking, truncation
// to the requested byte count and a done pulse after the final beat.
module shake_squeeze_dump #(
    parameter int W        = 64,
    parameter int MAX_RATE = 1344,
    parameter int NB_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                abort,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [MAX_RATE-1:0] blk_data,
    input  logic                blk_last,
    input  logic [NB_W-1:0]     blk_nbytes,
    output logic [W-1:0]        data_out,
    output logic [W/8-1:0]      keep_out,
    output logic                last_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                done,
    output logic                busy
);

    localparam int KW = W / 8;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    state_t              state_q;
    logic [MAX_RATE-1:0] buf_q;
    logic [NB_W-1:0]     beats_q;
    logic [NB_W-1:0]     cnt_q;
    logic [KW-1:0]       tail_keep_q;
    logic                last_q;

    logic [NB_W-1:0]     rate_bytes;
    logic [NB_W-1:0]     nb_d;
    logic [NB_W-1:0]     tail_d;
    logic [NB_W-1:0]     beats_d;
    logic [KW-1:0]       tail_keep_d;
    logic                accept;
    logic                xfer;
    logic                next_is_final;

    assign blk_ready     = (state_q == S_IDLE) && !rst && !abort;
    assign accept        = blk_valid && blk_ready;
    assign xfer          = valid_out && ready_in;
    assign busy          = (state_q != S_IDLE);
    // cnt_q indexes the beat currently presented; this flags the one after it
    assign next_is_final = ((cnt_q + NB_W'(2)) == beats_q);

    // Block geometry from the incoming request: clamped byte count, beat
    // count and the keep mask of the final (possibly partial) beat.
    always_comb begin
        rate_bytes  = mode ? NB_W'(136) : NB_W'(168);
        nb_d        = (blk_last && (blk_nbytes < rate_bytes)) ? blk_nbytes : rate_bytes;
        tail_d      = nb_d % NB_W'(KW);
        beats_d     = (nb_d / NB_W'(KW)) + NB_W'(tail_d != '0);
        tail_keep_d = '1;
        if (tail_d != '0)
            tail_keep_d = KW'((32'd1 << tail_d) - 32'd1);
    end

    // Control FSM with registered beat outputs; the buffer shifts right by W
    // each time a beat is loaded onto data_out so beat k is always at [W-1:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_q   <= S_IDLE;
                valid_out <= 1'b0;
                cnt_q     <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            buf_q       <= blk_data;
                            last_q      <= blk_last;
                            beats_q     <= beats_d;
                            tail_keep_q <= tail_keep_d;
                            cnt_q       <= '0;
                            state_q     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (beats_q == '0) begin
                            // empty last block: nothing to emit, just signal completion
                            done    <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            data_out  <= buf_q[W-1:0];
                            buf_q     <= buf_q >> W;
                            keep_out  <= (beats_q == NB_W'(1)) ? tail_keep_q : '1;
                            last_out  <= last_q && (beats_q == NB_W'(1));
                            valid_out <= 1'b1;
                            state_q   <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (xfer) begin
                            if (cnt_q == beats_q - NB_W'(1)) begin
                                valid_out <= 1'b0;
                                last_out  <= 1'b0;
                                cnt_q     <= '0;
                                done      <= last_q;
                                state_q   <= S_IDLE;
                            end else begin
                                data_out <= buf_q[W-1:0];
                                buf_q    <= buf_q >> W;
                                cnt_q    <= cnt_q + NB_W'(1);
                                keep_out <= next_is_final ? tail_keep_q : '1;
                                last_out <= last_q && next_is_final;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shake_squeeze_dump.sv
// Bench for shake_squeeze_dump: a byte-level model of the expected beat
// stream, a per-cycle compare process and a set of directed/random blocks.
module tb_shake_squeeze_dump;

    logic          clk;
    logic          rst;
    logic          mode;
    logic          abort;
    logic          blk_valid;
    logic          blk_ready;
    logic [1343:0] blk_data;
    logic          blk_last;
    logic [7:0]    blk_nbytes;
    logic [63:0]   data_out;
    logic [7:0]    keep_out;
    logic          last_out;
    logic          valid_out;
    logic          ready_in;
    logic          done;
    logic          busy;

    shake_squeeze_dump #(.W(64), .MAX_RATE(1344), .NB_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .abort(abort),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_nbytes(blk_nbytes),
        .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .valid_out(valid_out), .ready_in(ready_in), .done(done), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ready_in generator: 0 = always, 1 = pattern 1,0,0,1,0,1, 2 = random
    int rdy_mode = 0;
    initial begin
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int pi = 0;
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin ready_in = pat[pi]; pi = (pi + 1) % 6; end
                2:       ready_in = 1'($urandom_range(0, 1));
                default: ready_in = 1'b1;
            endcase
        end
    end

    // ---------------- reference model + compare ----------------
    logic [63:0] qd[$];
    logic [7:0]  qk[$];
    bit          ql[$];
    int          m_stage = 0;   // 0 idle, 1 capture-to-output gap, 2 emitting
    bit          m_last;
    bit          exp_done = 0;
    bit          stall_prev = 0;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat = -1;
    int          n_beats = 0;
    int          n_last = 0;
    int          n_done = 0;
    logic [7:0]  last_keep = '0;

    // expected beats for a block: bytes 8k..8k+7 of the first nb bytes
    task automatic build(input bit md, input bit lst, input logic [7:0] nbytes,
                         input logic [1343:0] d);
        int rate = md ? 136 : 168;
        int nb   = lst ? ((int'(nbytes) < rate) ? int'(nbytes) : rate) : rate;
        int n    = (nb + 7) / 8;
        for (int k = 0; k < n; k++) begin
            int rem = nb - 8 * k;
            qd.push_back(d[k*64 +: 64]);
            qk.push_back(rem >= 8 ? 8'hFF : 8'((1 << rem) - 1));
            ql.push_back(lst && (k == n - 1));
        end
        m_last = lst;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_blk_ready", 64'(blk_ready), 64'd0);
            m_stage = 0; exp_done = 0; stall_prev = 0;
            qd.delete(); qk.delete(); ql.delete();
        end else begin
            chk("blk_ready", 64'(blk_ready), 64'(m_stage == 0 && !abort));
            chk("valid_out", 64'(valid_out), 64'(m_stage == 2));
            chk("busy", 64'(busy), 64'(m_stage != 0));
            if (done || exp_done) chk("done", 64'(done), 64'(exp_done));
            if (done) n_done++;
            if (stall_prev) begin
                chk("stall_valid", 64'(valid_out), 64'd1);
                chk("stall_data", data_out, sd);
                chk("stall_keep", 64'(keep_out), 64'(sk));
                chk("stall_last", 64'(last_out), 64'(sl));
            end
            if (m_stage == 2 && valid_out) begin
                if (qd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_extra actual=%h required=none", data_out);
                end else begin
                    chk("beat_data", data_out, qd[0]);
                    chk("beat_keep", 64'(keep_out), 64'(qk[0]));
                    chk("beat_last", 64'(last_out), 64'(ql[0]));
                end
            end
            if (valid_out && lat < 0) lat = cyc - acc_cyc;
            stall_prev = valid_out && !ready_in && !abort;
            sd = data_out; sk = keep_out; sl = last_out;
            exp_done = 0;
            if (abort) begin
                m_stage = 0;
                qd.delete(); qk.delete(); ql.delete();
            end else begin
                case (m_stage)
                    0: if (blk_valid) begin
                        build(mode, blk_last, blk_nbytes, blk_data);
                        m_stage = 1; acc_cyc = cyc; lat = -1;
                    end
                    1: if (qd.size() == 0) begin m_stage = 0; exp_done = 1; end
                       else m_stage = 2;
                    2: if (ready_in) begin
                        n_beats++;
                        if (last_out) n_last++;
                        last_keep = keep_out;
                        if (qd.size() > 0) begin
                            void'(qd.pop_front()); void'(qk.pop_front()); void'(ql.pop_front());
                        end
                        if (qd.size() == 0) begin m_stage = 0; exp_done = m_last; end
                    end
                    default: m_stage = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        n_beats = 0; n_last = 0; n_done = 0; last_keep = '0;
    endtask

    task automatic send(input bit md, input bit lst, input logic [7:0] nb,
                        input logic [1343:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        blk_valid = 1'b1; mode = md; blk_last = lst; blk_nbytes = nb; blk_data = d;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (blk_ready) ok = 1;
            @(posedge clk); #1;
        end
        blk_valid = 1'b0;
        mode = 1'($urandom_range(0, 1));
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && !valid_out) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    function automatic logic [1343:0] pat_blk();
        logic [1343:0] d;
        for (int i = 0; i < 168; i++) d[i*8 +: 8] = 8'(i);
        return d;
    endfunction

    function automatic logic [1343:0] rnd_blk();
        logic [1343:0] d;
        for (int i = 0; i < 42; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        bit hit;
        rst = 1'b1; abort = 1'b0; blk_valid = 1'b0; mode = 1'b0;
        blk_last = 1'b0; blk_nbytes = '0; blk_data = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(valid_out), 64'd0);
        chk("reset_data", data_out, 64'd0);
        chk("reset_keep", 64'(keep_out), 64'd0);
        chk("reset_last", 64'(last_out), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ready", 64'(blk_ready), 64'd1);

        // full-rate SHAKE128 block, byte pattern, no backpressure
        clr(); rdy_mode = 0;
        send(1'b0, 1'b0, 8'd0, pat_blk());
        wait_idle();
        chk("t1_beats", 64'(n_beats), 64'd21);
        chk("t1_latency", 64'(lat), 64'd2);
        chk("t1_last", 64'(n_last), 64'd0);
        chk("t1_done", 64'(n_done), 64'd0);

        // SHAKE256 last block, 32 bytes
        clr();
        send(1'b1, 1'b1, 8'd32, rnd_blk());
        wait_idle();
        chk("t2_beats", 64'(n_beats), 64'd4);
        chk("t2_last", 64'(n_last), 64'd1);
        chk("t2_done", 64'(n_done), 64'd1);
        chk("t2_keep", 64'(last_keep), 64'hFF);

        // partial tail: 13 bytes
        clr();
        send(1'b0, 1'b1, 8'd13, pat_blk());
        wait_idle();
        chk("t3_beats", 64'(n_beats), 64'd2);
        chk("t3_tail_keep", 64'(last_keep), 64'h1F);

        // over-long request is clamped to the rate
        clr();
        send(1'b0, 1'b1, 8'd200, rnd_blk());
        wait_idle();
        chk("t4_beats", 64'(n_beats), 64'd21);
        chk("t4_tail_keep", 64'(last_keep), 64'hFF);

        // SHAKE256 full block under stall pattern
        clr(); rdy_mode = 1;
        send(1'b1, 1'b0, 8'd0, rnd_blk());
        wait_idle();
        chk("t5_beats", 64'(n_beats), 64'd17);
        rdy_mode = 0;

        // abort while beat 5 is presented
        clr();
        send(1'b0, 1'b0, 8'd0, pat_blk());
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            if (valid_out && n_beats == 5) hit = 1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL abort_setup actual=beat5_not_seen required=beat5");
        end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(valid_out), 64'd0);
        chk("abort_ready", 64'(blk_ready), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_beats", 64'(n_beats), 64'd5);
        @(posedge clk); #1;
        clr();
        send(1'b1, 1'b1, 8'd8, rnd_blk());
        wait_idle();
        chk("t6_beats", 64'(n_beats), 64'd1);
        chk("t6_last", 64'(n_last), 64'd1);

        // empty last block
        clr();
        send(1'b0, 1'b1, 8'd0, rnd_blk());
        wait_idle();
        chk("t7_beats", 64'(n_beats), 64'd0);
        chk("t7_done", 64'(n_done), 64'd1);

        // randomized blocks with random backpressure
        for (int i = 0; i < 25; i++) begin
            rdy_mode = $urandom_range(0, 2);
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 220)), rnd_blk());
            wait_idle();
        end
        rdy_mode = 0;

        // reset mid-stream
        clr();
        send(1'b0, 1'b0, 8'd0, rnd_blk());
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            if (n_beats >= 3) hit = 1;
            else begin @(posedge clk); #1; end
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(valid_out), 64'd0);
        chk("rst_mid_data", data_out, 64'd0);
        chk("rst_mid_keep", 64'(keep_out), 64'd0);
        chk("rst_mid_last", 64'(last_out), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
